alarm_key_ctrl: RTL and testbench

Front-panel edit controller for the alarm-time setter. Debounces three raw push-buttons (select, up, down) and steps a field-select state machine. Emits one-cycle increment/decrement pulses, with hold-to-auto-repeat, on the per-field `cnt_inc[2:0]` / `cnt_dec[2:0]` buses consumed directly by the alarm setter. `Field_sel` drives digit blinking in the display path.

---
 rtl/alarm_pkg.sv | 57 +++++
 rtl/key_debounce.sv | 64 ++++++
 rtl/alarm_key_ctrl.sv | 114 +++++++++++
 tb/tb_alarm_key_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm-time edit path: field encodings,
// default timing constants and small helpers used by the key controller.
package alarm_pkg;

  // One-hot field select values (000 = not editing)
  localparam logic [2:0] FLD_NONE = 3'b000;
  localparam logic [2:0] FLD_SEC  = 3'b001;
  localparam logic [2:0] FLD_MIN  = 3'b010;
  localparam logic [2:0] FLD_HOUR = 3'b100;

  // Bit positions in cnt_inc / cnt_dec, shared with the alarm setter
  localparam int FIDX_SEC  = 0;
  localparam int FIDX_MIN  = 1;
  localparam int FIDX_HOUR = 2;

  // Default timing in clk cycles at 50 MHz
  localparam int DEF_DEB_CYCLES    = 1_000_000;   // 20 ms
  localparam int DEF_HOLD_CYCLES   = 25_000_000;  // 500 ms
  localparam int DEF_REPEAT_CYCLES = 5_000_000;   // 100 ms

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEC  = 2'd1,
    ST_MIN  = 2'd2,
    ST_HOUR = 2'd3
  } field_e;

  typedef enum logic [1:0] {
    REP_NONE = 2'd0,
    REP_UP   = 2'd1,
    REP_DOWN = 2'd2
  } rep_e;

  function automatic logic [2:0] field_onehot(input field_e f);
    case (f)
      ST_SEC:  return FLD_SEC;
      ST_MIN:  return FLD_MIN;
      ST_HOUR: return FLD_HOUR;
      default: return FLD_NONE;
    endcase
  endfunction

  function automatic field_e next_field(input field_e f);
    case (f)
      ST_IDLE: return ST_SEC;
      ST_SEC:  return ST_MIN;
      ST_MIN:  return ST_HOUR;
      default: return ST_IDLE;
    endcase
  endfunction

  // Bits needed to hold the larger of the two repeat intervals
  function automatic int timer_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-FF synchronizer plus stable-level debouncer for one active-low key.
// o_press strobes for one cycle when the debounced level falls, but only
// once the key has been seen released since reset, so a key held through
// reset never produces a press.
module key_debounce
  import alarm_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic          r_armed;
  logic [CW-1:0] r_cnt;

  // Synchronizer starts at "pressed" so the first settled sample decides arming
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level after it has persisted; any bounce restarts the count
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEB_CYCLES)) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_press <= r_armed & ~r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_level && r_sync2) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/alarm_key_ctrl.sv
// Front-panel edit controller: field-select FSM, hold-to-repeat timer and
// per-field increment/decrement pulse encoding.
//
// state   | meaning
// ST_IDLE | not editing, up/down ignored
// ST_SEC  | editing seconds (bit 0)
// ST_MIN  | editing minutes (bit 1)
// ST_HOUR | editing hours   (bit 2)
module alarm_key_ctrl
  import alarm_pkg::*;
#(
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Key_sel_n,
  input  logic       Key_up_n,
  input  logic       Key_down_n,
  output logic [2:0] cnt_inc,
  output logic [2:0] cnt_dec,
  output logic [2:0] Field_sel
);

  localparam int TW = timer_width(HOLD_CYCLES, REPEAT_CYCLES);

  logic w_sel_level_unused;
  logic w_sel_press;
  logic w_up_lvl, w_up_press;
  logic w_dn_lvl, w_dn_press;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sel (
    .Clk(Clk), .Reset_n(Reset_n), .i_key_n(Key_sel_n),
    .o_level(w_sel_level_unused), .o_press(w_sel_press)
  );
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .Clk(Clk), .Reset_n(Reset_n), .i_key_n(Key_up_n),
    .o_level(w_up_lvl), .o_press(w_up_press)
  );
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
    .Clk(Clk), .Reset_n(Reset_n), .i_key_n(Key_down_n),
    .o_level(w_dn_lvl), .o_press(w_dn_press)
  );

  field_e        r_field,  w_field_nxt;
  rep_e          r_rep,    w_rep_nxt;
  logic [TW-1:0] r_timer,  w_timer_nxt;
  logic [2:0]    r_inc,    w_inc_nxt;
  logic [2:0]    r_dec,    w_dec_nxt;
  logic [2:0]    r_fsel;
  logic [2:0]    w_fmask;

  // Priority: select, then both-held abort, then fresh press, then repeat
  always_comb begin
    w_field_nxt = r_field;
    w_rep_nxt   = r_rep;
    w_timer_nxt = r_timer;
    w_inc_nxt   = '0;
    w_dec_nxt   = '0;
    w_fmask     = field_onehot(r_field);
    if (w_sel_press) begin
      w_field_nxt = next_field(r_field);
      w_rep_nxt   = REP_NONE;
      w_timer_nxt = '0;
    end else if (!w_up_lvl && !w_dn_lvl) begin
      w_rep_nxt   = REP_NONE;
      w_timer_nxt = '0;
    end else if (r_field != ST_IDLE && w_up_press) begin
      w_inc_nxt   = w_fmask;
      w_rep_nxt   = REP_UP;
      w_timer_nxt = TW'(HOLD_CYCLES - 1);
    end else if (r_field != ST_IDLE && w_dn_press) begin
      w_dec_nxt   = w_fmask;
      w_rep_nxt   = REP_DOWN;
      w_timer_nxt = TW'(HOLD_CYCLES - 1);
    end else if (r_rep != REP_NONE) begin
      if ((r_rep == REP_UP && w_up_lvl) || (r_rep == REP_DOWN && w_dn_lvl)) begin
        w_rep_nxt   = REP_NONE;
        w_timer_nxt = '0;
      end else if (r_timer == '0) begin
        if (r_rep == REP_UP) w_inc_nxt = w_fmask;
        else                 w_dec_nxt = w_fmask;
        w_timer_nxt = TW'(REPEAT_CYCLES - 1);
      end else begin
        w_timer_nxt = r_timer - 1'b1;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_field <= ST_IDLE;
      r_rep   <= REP_NONE;
      r_timer <= '0;
      r_inc   <= '0;
      r_dec   <= '0;
      r_fsel  <= FLD_NONE;
    end else begin
      r_field <= w_field_nxt;
      r_rep   <= w_rep_nxt;
      r_timer <= w_timer_nxt;
      r_inc   <= w_inc_nxt;
      r_dec   <= w_dec_nxt;
      r_fsel  <= field_onehot(w_field_nxt);
    end
  end

  assign cnt_inc   = r_inc;
  assign cnt_dec   = r_dec;
  assign Field_sel = r_fsel;

endmodule

// File: tb/tb_alarm_key_ctrl.sv
// Scoreboard bench for alarm_key_ctrl with small timing parameters.
module tb_alarm_key_ctrl;

  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int REP  = 8;
  localparam int LAT  = DEB + 3;   // raw edge to output edge

  logic clk, rst_n, sel_n, up_n, dn_n;
  logic [2:0] inc, dec, fsel;

  alarm_key_ctrl #(.DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut (
    .Clk(clk), .Reset_n(rst_n), .Key_sel_n(sel_n), .Key_up_n(up_n),
    .Key_down_n(dn_n), .cnt_inc(inc), .cnt_dec(dec), .Field_sel(fsel)
  );

  typedef struct { int t; logic [2:0] inc; logic [2:0] dec; } pev_t;
  typedef struct { int t; logic [2:0] f; } fev_t;

  pev_t pq[$];
  fev_t fq[$];
  pev_t mp;
  fev_t mf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fld = 0;           // 0 idle, 1 sec, 2 min, 3 hour
  logic [2:0] last_f = 3'b000;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] fmask(input int f);
    logic [2:0] m;
    m = 3'b000;
    if (f > 0) m[f-1] = 1'b1;
    return m;
  endfunction

  // Monitor: every pulse or field change must match the head of its queue
  always @(negedge clk) begin
    if (!rst_n) begin
      last_f = fsel;
    end else begin
      if ((inc | dec) != 3'b000) begin
        checks++;
        if ($countones({inc, dec}) != 1) begin
          errors++;
          $display("FAIL onehot: cyc %0d inc=%b dec=%b, required exactly one bit", cyc, inc, dec);
        end
        checks++;
        if (pq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: cyc %0d inc=%b dec=%b, required none", cyc, inc, dec);
        end else begin
          mp = pq.pop_front();
          if (mp.t != cyc || mp.inc !== inc || mp.dec !== dec) begin
            errors++;
            $display("FAIL pulse: cyc %0d inc=%b dec=%b, required cyc %0d inc=%b dec=%b",
                     cyc, inc, dec, mp.t, mp.inc, mp.dec);
          end
        end
      end
      if (fsel !== last_f) begin
        checks++;
        if (fq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_field: cyc %0d field=%b, required %b", cyc, fsel, last_f);
        end else begin
          mf = fq.pop_front();
          if (mf.t != cyc || mf.f !== fsel) begin
            errors++;
            $display("FAIL field: cyc %0d field=%b, required cyc %0d field=%b", cyc, fsel, mf.t, mf.f);
          end
        end
      end
      last_f = fsel;
    end
  end

  task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, required %b", nm, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_pulse(input int t, input bit is_up, input int f);
    pev_t p;
    p.t   = t;
    p.inc = is_up ? fmask(f) : 3'b000;
    p.dec = is_up ? 3'b000 : fmask(f);
    pq.push_back(p);
  endtask

  task automatic press_sel();
    fev_t e;
    e.t = cyc + 1 + LAT;
    sel_n = 1'b0;
    fld = (fld + 1) % 4;
    e.f = fmask(fld);
    fq.push_back(e);
    wait_cyc(10);
    sel_n = 1'b1;
    wait_cyc(12);
  endtask

  // Hold up or down so that exactly n repeats follow the press pulse
  task automatic hold_key(input bit is_up, input int n);
    int e, p, r;
    e = cyc + 1;
    if (is_up) up_n = 1'b0; else dn_n = 1'b0;
    p = e + LAT;
    if (fld != 0) begin
      push_pulse(p, is_up, fld);
      for (int k = 0; k < n; k++) push_pulse(p + HOLD + k * REP, is_up, fld);
    end
    r = p - (DEB + 2) + ((n == 0) ? HOLD / 2 : HOLD + (n - 1) * REP + REP / 2);
    wait_cyc(r - e);
    if (is_up) up_n = 1'b1; else dn_n = 1'b1;
    wait_cyc(12);
  endtask

  initial begin
    int e, p;
    fev_t fe;
    rst_n = 1'b0; sel_n = 1'b1; up_n = 1'b1; dn_n = 1'b1;
    #1;
    chk("reset_inc", inc, 3'b000);
    chk("reset_dec", dec, 3'b000);
    chk("reset_field", fsel, 3'b000);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(10);

    // Field walk through all four states
    repeat (4) press_sel();

    // IDLE: up and down together do nothing
    up_n = 1'b0; dn_n = 1'b0;
    wait_cyc(30);
    up_n = 1'b1; dn_n = 1'b1;
    wait_cyc(12);

    // SEC: simultaneous up/down press edges give no pulse
    press_sel();
    up_n = 1'b0; dn_n = 1'b0;
    wait_cyc(40);
    up_n = 1'b1; dn_n = 1'b1;
    wait_cyc(12);

    // SEC: bouncing down key, one pulse after the stable fall
    for (int b = 0; b < 3; b++) begin
      dn_n = 1'b0; wait_cyc(3);
      dn_n = 1'b1; wait_cyc(1);
    end
    hold_key(1'b0, 0);

    // SEC: select and up edges together, select wins
    sel_n = 1'b0; up_n = 1'b0;
    fld = 2;
    fe.t = cyc + 1 + LAT; fe.f = fmask(fld);
    fq.push_back(fe);
    wait_cyc(10);
    sel_n = 1'b1;
    wait_cyc(30);
    up_n = 1'b1;
    wait_cyc(12);

    // MIN: up held, pulses at +0, +20, +28, +36
    hold_key(1'b1, 3);

    // Randomized field/key/hold mix
    for (int it = 0; it < 8; it++) begin
      int ns;
      ns = $urandom_range(0, 2);
      repeat (ns) press_sel();
      hold_key($urandom_range(0, 1) == 1, $urandom_range(0, 3));
    end

    // HOUR: up held then down pressed aborts the repeat
    while (fld != 3) press_sel();
    e = cyc + 1;
    up_n = 1'b0;
    push_pulse(e + LAT, 1'b1, fld);
    wait_cyc(10);
    dn_n = 1'b0;
    wait_cyc(30);
    dn_n = 1'b1;
    wait_cyc(40);
    up_n = 1'b1;
    wait_cyc(12);
    hold_key(1'b1, 0);

    // SEC: up held through a select press, no pulse to the new field
    while (fld != 1) press_sel();
    e = cyc + 1;
    up_n = 1'b0;
    push_pulse(e + LAT, 1'b1, fld);
    wait_cyc(9);
    sel_n = 1'b0;
    fld = 2;
    fe.t = cyc + 1 + LAT; fe.f = fmask(fld);
    fq.push_back(fe);
    wait_cyc(10);
    sel_n = 1'b1;
    wait_cyc(40);
    up_n = 1'b1;
    wait_cyc(12);

    // MIN: reset mid-repeat, then nothing while up stays held
    e = cyc + 1;
    up_n = 1'b0;
    p = e + LAT;
    push_pulse(p, 1'b1, fld);
    push_pulse(p + HOLD, 1'b1, fld);
    wait_cyc(p + HOLD + 5 - cyc);
    rst_n = 1'b0;
    #1;
    chk("midreset_inc", inc, 3'b000);
    chk("midreset_dec", dec, 3'b000);
    chk("midreset_field", fsel, 3'b000);
    wait_cyc(3);
    rst_n = 1'b1;
    fld = 0;
    wait_cyc(60);
    up_n = 1'b1;
    wait_cyc(12);

    // Recovery after a genuine release
    press_sel();
    hold_key(1'b1, 1);

    wait_cyc(20);
    chk("final_inc", inc, 3'b000);
    checks++;
    if (pq.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses: %0d still queued, required 0", pq.size());
    end
    checks++;
    if (fq.size() != 0) begin
      errors++;
      $display("FAIL missing_fields: %0d still queued, required 0", fq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
